// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
// Writeback source select codes, load funct3 codes and the datapath width.
package riscv_pkg;

  localparam int XLEN = 32;

  // Writeback source select (2 bits)
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  // Load funct3 encodings (3 bits)
  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

endpackage

// File: rtl/load_align.sv
// load_align: purely combinational load-data formatter.
// Ports:
//   word    in  32  raw little-endian DRAM read word
//   addr_lo in  2   byte address bits [1:0]
//   ld_type in  3   load funct3 (LB/LH/LW/LBU/LHU)
//   data    out 32  extracted and sign/zero-extended load value
// Unknown ld_type codes pass the raw word through unchanged.
import riscv_pkg::*;

module load_align (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      ld_type,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Halfword loads ignore addr_lo[0]; misaligned accesses trap upstream.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'd0, half_sel};
      LD_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback formatter.
// Ports:
//   clk, rst_n (async, active-low), stall, flush
//   in_valid, in_rf_we, in_rd, in_wb_sel, in_ld_type, in_addr_lo,
//   in_alu_res, in_pc4, in_imm, in_dram_rdata   MEM-stage results
//   rf_we, wR, wD    register-file write port (also the WB forwarding source)
//   wb_valid         WB holds a valid instruction
// Optional: define MEM_WB_INSTRET_EN to add a 64-bit retired-instruction
// counter on output port instret.
import riscv_pkg::*;

module mem_wb_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_rf_we,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_ld_type,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_dram_rdata,
  output logic            rf_we,
  output logic [4:0]      wR,
  output logic [XLEN-1:0] wD,
  output logic            wb_valid
`ifdef MEM_WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  logic            valid_q;
  logic            rf_we_q;
  logic [4:0]      rd_q;
  logic [1:0]      wb_sel_q;
  logic [2:0]      ld_type_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] dram_q;
  logic [XLEN-1:0] load_fmt;

  // Flush beats stall; a flushed slot is fully zeroed, not just invalidated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      valid_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= '0;
      ld_type_q <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
      imm_q     <= '0;
      dram_q    <= '0;
    end else if (!stall) begin
      valid_q   <= in_valid;
      rf_we_q   <= in_rf_we;
      rd_q      <= in_rd;
      wb_sel_q  <= in_wb_sel;
      ld_type_q <= in_ld_type;
      addr_lo_q <= in_addr_lo;
      alu_q     <= in_alu_res;
      pc4_q     <= in_pc4;
      imm_q     <= in_imm;
      dram_q    <= in_dram_rdata;
    end
  end

  load_align u_load_align (
    .word    (dram_q),
    .addr_lo (addr_lo_q),
    .ld_type (ld_type_q),
    .data    (load_fmt)
  );

  assign wb_valid = valid_q;
  // x0 writes are suppressed here so the register file never sees them.
  assign rf_we    = valid_q & rf_we_q & (rd_q != 5'd0);
  assign wR       = valid_q ? rd_q : 5'd0;

  always_comb begin
    wD = '0;
    if (valid_q) begin
      case (wb_sel_q)
        WB_SEL_ALU:  wD = alu_q;
        WB_SEL_LOAD: wD = load_fmt;
        WB_SEL_PC4:  wD = pc4_q;
        WB_SEL_IMM:  wD = imm_q;
        default:     wD = alu_q;
      endcase
    end
  end

`ifdef MEM_WB_INSTRET_EN
  // An instruction retires as it leaves WB, i.e. when WB is valid and not held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (valid_q && !stall) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage using a scoreboard queue of expected
// writeback outputs.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_rf_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_ld_type;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic [31:0] in_pc4;
  logic [31:0] in_imm;
  logic [31:0] in_dram_rdata;
  logic        rf_we;
  logic [4:0]  wR;
  logic [31:0] wD;
  logic        wb_valid;
`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] cntModel;
`endif

  mem_wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_rf_we      (in_rf_we),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_ld_type    (in_ld_type),
    .in_addr_lo    (in_addr_lo),
    .in_alu_res    (in_alu_res),
    .in_pc4        (in_pc4),
    .in_imm        (in_imm),
    .in_dram_rdata (in_dram_rdata),
    .rf_we         (rf_we),
    .wR            (wR),
    .wD            (wD),
    .wb_valid      (wb_valid)
`ifdef MEM_WB_INSTRET_EN
    ,
    .instret       (instret)
`endif
  );

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  exp_t expQ[$];
  exp_t heldModel;
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference load formatter written with shifts rather than case tables.
  function automatic logic [31:0] modelLoad(input logic [31:0] dram, input logic [2:0] ldt,
                                            input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = (dram >> (8 * lo)) & 32'hFF;
    h = (dram >> (16 * lo[1])) & 32'hFFFF;
    case (ldt)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return dram;
    endcase
  endfunction

  // Drive one MEM-stage beat at the falling edge and push what WB should show
  // after the next rising edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic v, input logic we,
                               input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] ldt,
                               input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [31:0] imm, input logic [31:0] dram);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; in_valid = v; in_rf_we = we; in_rd = rd; in_wb_sel = sel;
    in_ld_type = ldt; in_addr_lo = lo; in_alu_res = alu; in_pc4 = pc4; in_imm = imm;
    in_dram_rdata = dram;
`ifdef MEM_WB_INSTRET_EN
    if (heldModel.v && !st) cntModel = cntModel + 64'd1;
`endif
    if (fl) begin
      e = '0;
    end else if (st) begin
      e = heldModel;
    end else if (!v) begin
      e = '0;
    end else begin
      e.v  = 1'b1;
      e.we = we && (rd != 5'd0);
      e.wr = rd;
      case (sel)
        2'd0:    e.wd = alu;
        2'd1:    e.wd = modelLoad(dram, ldt, lo);
        2'd2:    e.wd = pc4;
        default: e.wd = imm;
      endcase
    end
    heldModel = e;
    expQ.push_back(e);
  endtask

  // Advance past the rising edge and compare against the oldest expectation.
  task automatic stepAndCheck(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, got output with no expectation", tag);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, e.v});
      checkOutput({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, e.we});
      checkOutput({tag, ".wR"}, {59'd0, wR}, {59'd0, e.wr});
      checkOutput({tag, ".wD"}, {32'd0, wD}, {32'd0, e.wd});
    end
`ifdef MEM_WB_INSTRET_EN
    checkOutput({tag, ".instret"}, instret, cntModel);
`endif
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, ".wb_valid"}, {63'd0, wb_valid}, 64'd0);
    checkOutput({tag, ".rf_we"}, {63'd0, rf_we}, 64'd0);
    checkOutput({tag, ".wR"}, {59'd0, wR}, 64'd0);
    checkOutput({tag, ".wD"}, {32'd0, wD}, 64'd0);
  endtask

  localparam logic [31:0] DRAM = 32'h80FF_7F01;

  initial begin
    vectors = 0; miscompares = 0; heldModel = '0;
`ifdef MEM_WB_INSTRET_EN
    cntModel = '0;
`endif
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rf_we = 1'b0;
    in_rd = '0; in_wb_sel = '0; in_ld_type = '0; in_addr_lo = '0; in_alu_res = '0;
    in_pc4 = '0; in_imm = '0; in_dram_rdata = '0;
    #12;
    checkZeroOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Bubbles after release
    applyStimulus(0, 0, 0, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 0, 0);
    stepAndCheck("bubble");

    // ALU writeback
    applyStimulus(0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 0, 0, 0);
    stepAndCheck("alu");

    // Mid-cycle reset clears outputs immediately
    #2;
    rst_n = 1'b0;
    #1;
    checkZeroOutputs("async_reset");
    heldModel = '0;
`ifdef MEM_WB_INSTRET_EN
    cntModel = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Load formatting
    applyStimulus(0, 0, 1, 1, 5'd8, 2'd1, 3'd0, 2'd3, 0, 0, 0, DRAM);
    stepAndCheck("lb_lo3");
    applyStimulus(0, 0, 1, 1, 5'd9, 2'd1, 3'd4, 2'd1, 0, 0, 0, DRAM);
    stepAndCheck("lbu_lo1");
    applyStimulus(0, 0, 1, 1, 5'd10, 2'd1, 3'd1, 2'd2, 0, 0, 0, DRAM);
    stepAndCheck("lh_lo2");
    applyStimulus(0, 0, 1, 1, 5'd11, 2'd1, 3'd5, 2'd0, 0, 0, 0, DRAM);
    stepAndCheck("lhu_lo0");
    applyStimulus(0, 0, 1, 1, 5'd12, 2'd1, 3'd2, 2'd3, 0, 0, 0, DRAM);
    stepAndCheck("lw");
    applyStimulus(0, 0, 1, 1, 5'd13, 2'd1, 3'd7, 2'd1, 0, 0, 0, DRAM);
    stepAndCheck("ld_undef");
    applyStimulus(0, 0, 1, 1, 5'd14, 2'd1, 3'd1, 2'd3, 0, 0, 0, DRAM);
    stepAndCheck("lh_lo3");

    // x0 suppression and select paths
    applyStimulus(0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 0, 0, 0);
    stepAndCheck("x0");
    applyStimulus(0, 0, 1, 1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h1, 32'h104, 32'h2, 0);
    stepAndCheck("pc4");
    applyStimulus(0, 0, 1, 1, 5'd2, 2'd3, 3'd0, 2'd0, 32'h1, 32'h2, 32'hABCD_E000, 0);
    stepAndCheck("imm");
    applyStimulus(0, 0, 1, 0, 5'd6, 2'd0, 3'd0, 2'd0, 32'h77, 0, 0, 0);
    stepAndCheck("no_we");

    // Stall holds a captured rd=7 while inputs keep changing
    applyStimulus(0, 0, 1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'hCAFE_0007, 0, 0, 0);
    stepAndCheck("cap_rd7");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 1, 5'(20 + i), 2'(i), 3'd0, 2'd0, $urandom, $urandom, $urandom, $urandom);
      stepAndCheck("stall_hold");
    end

    // Flush wins over a simultaneous stall
    applyStimulus(1, 1, 1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h99, 0, 0, 0);
    stepAndCheck("stall_flush");

    // Flush alone on a valid instruction
    applyStimulus(0, 0, 1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h44, 0, 0, 0);
    stepAndCheck("pre_flush");
    applyStimulus(0, 1, 1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h45, 0, 0, 0);
    stepAndCheck("flush");

    // Random mix through the scoreboard
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
                    1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
                    $urandom, $urandom, $urandom, $urandom);
      stepAndCheck("random");
    end

`ifdef MEM_WB_INSTRET_EN
    // Counter wrap from a forced near-maximum value
    applyStimulus(0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h3, 0, 0, 0);
    stepAndCheck("pre_wrap");
    @(negedge clk);
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    cntModel = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0);
    stepAndCheck("wrap");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatter for the 5-stage RV32I pipeline.
- Captures MEM-stage results on posedge clk, extracts and sign/zero-extends load data, selects the writeback source, and drives the register-file write port (rf_we, wR, wD).
- The register file writes on negedge clk, so a value registered here on a posedge is committed in the same cycle.
- wD also serves as the WB forwarding source for the hazard/forwarding unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  insert a bubble into WB.
- in_valid  in  1  MEM stage holds a real instruction.
- in_rf_we  in  1  instruction writes rd.
- in_rd  in  5  destination register index.
- in_wb_sel  in  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 immediate.
- in_ld_type  in  3  load funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- in_addr_lo  in  2  ALU address bits [1:0] for the load.
- in_alu_res  in  32  ALU result.
- in_pc4  in  32  PC+4.
- in_imm  in  32  immediate (LUI).
- in_dram_rdata  in  32  raw DRAM read word, little-endian.
- rf_we  out  1  register-file write enable.
- wR  out  5  register-file write index.
- wD  out  32  register-file write data.
- wb_valid  out  1  WB holds a valid instruction.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registered fields and valid_q.
  - Outputs under reset: rf_we=0, wR=0, wD=0, wb_valid=0.
  - Deassertion takes effect at the next posedge.
- Register update priority on posedge: flush > stall > capture.
  - flush=1: valid_q<=0; other fields are don't-care but are cleared to 0. Flush overrides a simultaneous stall.
  - stall=1 (flush=0): all fields hold.
  - Otherwise: capture all in_* fields; valid_q<=in_valid.
- Latency: 1 cycle from MEM inputs to WB outputs. Outputs are combinational from registered fields only, with no combinational path from in_*.
- Output equations:
  - wb_valid = valid_q.
  - rf_we = valid_q & rf_we_q & (rd_q != 0). Writes to x0 are suppressed here as well.
  - wR = rd_q when valid_q, else 0.
  - wD is 0 when valid_q=0; otherwise selected by wb_sel_q: 0 alu_q, 1 load_fmt, 2 pc4_q, 3 imm_q.
- Load formatting (load_fmt, from dram_q and addr_lo_q):
  - LB/LBU: byte addr_lo_q; sign- or zero-extended.
  - LH/LHU: halfword addr_lo_q[1]; addr_lo_q[0] ignored, since misalignment is trapped upstream.
  - LW: full word; addr_lo_q ignored.
  - Undefined ld_type (3, 6, 7): load_fmt = dram_q.
- Stall while holding a valid write: rf_we stays asserted, so the register file rewrites the same value each cycle (idempotent).
- Reset mid-stall or mid-flush: reset wins immediately.

Optional Feature:
- Macro: MEM_WB_INSTRET_EN.
- Defined:
  - Adds output port instret, 64 bits.
  - The counter increments at a posedge when valid_q=1 and stall=0 (the instruction retires as it leaves WB).
  - Cleared by rst_n; wraps at 2^64-1 to 0.
- Undefined: no counter and no instret port; all other behaviour is identical.

Decomposition:
- Package riscv_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/IMM codes, 2 bits.
  - LD_LB/LH/LW/LBU/LHU codes, 3 bits.
  - XLEN constant.
- One sub-module, load_align: purely combinational dram word + addr_lo + ld_type -> 32-bit formatted load data. It is reused by any future load path.

Test Plan:
- Reset and bubble:
  - Assert rst_n=0 mid-cycle -> rf_we=0, wR=0, wD=0, wb_valid=0 immediately.
  - After release with in_valid=0 -> outputs stay 0.
- ALU writeback: in_valid=1, in_rf_we=1, rd=5, sel=0, alu=0x1234_5678 -> next cycle rf_we=1, wR=5, wD=0x12345678.
- Load formatting: dram=0x80FF_7F01.
  - LB, lo=3 -> wD=0xFFFFFF80.
  - LBU, lo=1 -> 0x0000007F.
  - LH, lo=2 -> 0xFFFF80FF.
  - LHU, lo=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- x0 and select paths:
  - rd=0, rf_we=1 -> rf_we out=0.
  - sel=2, pc4=0x104 -> wD=0x104.
  - sel=3, imm=0xABCD_E000 -> wD=0xABCDE000.
- Stall/flush priority:
  - Capture rd=7, then stall=1 for 3 cycles with changing inputs -> wR=7 and wD held.
  - stall=1 and flush=1 together -> next cycle wb_valid=0, rf_we=0.
- With MEM_WB_INSTRET_EN: 4 valid instructions including 1 stalled cycle -> instret=4.
  - Preload the count near 2^64-1 via a forced value -> wraps to 0.
